// File: rtl/fifo_rd_uart_tx_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: FSM state
// encoding, parity-type codes and a small state-classification helper.
package fifo_rd_uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // True in the states that occupy whole bit times on the serial line.
  function automatic logic is_serial_state(input state_t st);
    return (st == ST_START) || (st == ST_DATA) || (st == ST_PARITY) || (st == ST_STOP);
  endfunction

endpackage

// File: rtl/fifo_rd_uart_tx_bit_timer.sv
// Baud divider: counts 0..DIV-1 while ACTIVE and pulses BIT_DONE on the
// last clock of each bit time. A divisor of 0 behaves as 1.
module uart_tx_bit_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic                 ACTIVE,
  output logic                 BIT_DONE
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] div_eff;

  assign div_eff  = (DIV == '0) ? DIV_WIDTH'(1) : DIV;
  assign BIT_DONE = ACTIVE && (cnt_q == (div_eff - DIV_WIDTH'(1)));

  // Next count: restart at each bit boundary and whenever the line is not serialising.
  always_comb begin
    cnt_d = cnt_q;
    if (!ACTIVE || BIT_DONE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Divider counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_uart_tx.sv
// Read-side FIFO consumer: pops one byte per frame and sends it as a UART
// frame (start, data LSB first, optional parity, one stop) on TX_OUT.
module fifo_rd_uart_tx
  import fifo_rd_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_R_INC,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [DIV_WIDTH-1:0]  DIV,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  par_en_q,  par_en_d;
  logic                  parity_q,  parity_d;
  logic [DIV_WIDTH-1:0]  div_q,     div_d;
  logic                  tx_q,      tx_d;
  logic                  bit_done;

  uart_tx_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .DIV      (div_q),
    .ACTIVE   (is_serial_state(state_q)),
    .BIT_DONE (bit_done)
  );

  // Pop strobe and busy flag are pure state decodes, so FIFO_EMPTY never reaches them.
  assign FIFO_R_INC = (state_q == ST_FETCH);
  assign BUSY       = (state_q != ST_IDLE);
  assign TX_OUT     = tx_q;

  // Frame sequencing; the line level is derived from the next state so TX_OUT is registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    parity_d  = parity_q;
    div_d     = div_q;
    case (state_q)
      ST_IDLE: begin
        if (!FIFO_EMPTY) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Snapshot byte and line configuration; later config changes wait for the next frame.
        shift_d   = FIFO_RD_DATA;
        par_en_d  = PAR_EN;
        parity_d  = (^FIFO_RD_DATA) ^ (PAR_TYP == PAR_ODD);
        div_d     = (DIV == '0) ? DIV_WIDTH'(1) : DIV;
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Back-to-back frames go straight to FETCH, costing one idle clock only.
        if (bit_done) state_d = FIFO_EMPTY ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and frame registers; reset truncates any frame in flight and idles the line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
      div_q     <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      parity_q  <= parity_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
    end
  end

endmodule
